// File: rtl/adder_acc_ctrl_pkg.sv
// Shared encodings and defaults for the switch/button accumulator front end.
package adder_acc_ctrl_pkg;

    // Accumulator control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Latched operation
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Stable cycles before a debounced level may change (hardware default)
    localparam int DB_COUNT_DEF = 1000000;
    localparam int DB_W_DEF     = 20;

endpackage

// File: rtl/btn_debounce.sv
// Per-button synchronizer, debouncer and rising-edge press pulse.
module btn_debounce #(
    parameter int DB_COUNT = 4,
    parameter int DB_W     = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press
);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    // Counter runs only while the synced input disagrees with the level;
    // the level flips once the disagreement has lasted DB_COUNT cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_W'(DB_COUNT - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and registered press pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/adder_acc_ctrl.sv
// Button-driven 8-bit add/subtract accumulator feeding the display stage.
module adder_acc_ctrl
    import adder_acc_ctrl_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF,
    parameter int DB_W     = DB_W_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] sw,
    input  logic       btn_add,
    input  logic       btn_sub,
    output logic [7:0] x,
    output logic       ovf,
    output logic       upd
);

    logic [7:0] sw_s1_q, sw_s_q;
    logic       lvl_add, lvl_sub, press_add, press_sub;
    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [7:0] x_q, x_d;
    logic       ovf_q, ovf_d;
    logic       upd_q, upd_d;
    logic [8:0] res;

    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_add (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_add),
        .level (lvl_add),
        .press (press_add)
    );

    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_sub (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_sub),
        .level (lvl_sub),
        .press (press_sub)
    );

    // Two-flop synchronizer for the operand switches
    always_ff @(posedge clk) begin
        if (clr) begin
            sw_s1_q <= '0;
            sw_s_q  <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s_q  <= sw_s1_q;
        end
    end

    // Next state: one operation per press, then wait for all buttons released
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        res     = '0;
        case (state_q)
            S_IDLE: begin
                if (press_add && press_sub) begin
                    state_d = S_HOLD;
                end else if (press_add || press_sub) begin
                    op_d    = press_sub ? OP_SUB : OP_ADD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Bit 8 is the carry for ADD and the borrow for SUB
                if (op_q == OP_SUB) res = {1'b0, x_q} - {1'b0, sw_s_q};
                else                res = {1'b0, x_q} + {1'b0, sw_s_q};
                x_d     = res[7:0];
                ovf_d   = ovf_q | res[8];
                upd_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!lvl_add && !lvl_sub) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and accumulator registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            x_q     <= '0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
        end
    end

    assign x   = x_q;
    assign ovf = ovf_q;
    assign upd = upd_q;

endmodule

// File: tb/tb_adder_acc_ctrl.sv
// Scoreboard bench: each issued operation queues its expected {ovf, x};
// a monitor pops and compares on every upd strobe.
module tb_adder_acc_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] sw;
    logic       btn_add, btn_sub;
    logic [7:0] x;
    logic       ovf, upd;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    adder_acc_ctrl #(.DB_COUNT(4), .DB_W(20)) dut (
        .clk     (clk),
        .clr     (clr),
        .sw      (sw),
        .btn_add (btn_add),
        .btn_sub (btn_sub),
        .x       (x),
        .ovf     (ovf),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    // Monitor: every upd must match the oldest queued expectation
    always @(negedge clk) begin
        if (upd) begin
            logic [8:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: got x=%02h ovf=%0d, no operation expected", x, ovf);
            end else begin
                e = exp_q.pop_front();
                if ({ovf, x} !== e) begin
                    errors++;
                    $display("FAIL upd_result: got ovf=%0d x=%02h, expected ovf=%0d x=%02h",
                             ovf, x, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %03h, expected %03h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until every queued operation has been observed
    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected upd pulses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Press a button for hold cycles, release and let it settle
    task automatic press(input bit sub, input logic [7:0] val, input logic [8:0] exp);
        sw = val;
        exp_q.push_back(exp);
        if (sub) btn_sub = 1'b1; else btn_add = 1'b1;
        cyc(50);
        btn_add = 1'b0;
        btn_sub = 1'b0;
        cyc(20);
    endtask

    initial begin
        clr = 1'b1; sw = 8'($urandom); btn_add = 1'($urandom); btn_sub = 1'($urandom);
        cyc(1);
        chk("reset_state", {upd, ovf, x}, 9'h000);
        sw = 8'($urandom); btn_add = 1'b0; btn_sub = 1'b0;
        cyc(1);
        chk("reset_state2", {upd, ovf, x}, 9'h000);
        clr = 1'b0;
        cyc(5);

        // Single add, then a second press
        press(1'b0, 8'h2A, 9'h02A);
        drain("add1");
        chk("add1_x", {ovf, x}, 9'h02A);
        press(1'b0, 8'h2A, 9'h054);
        drain("add2");

        // Bounce rejection: 2-cycle glitches never settle
        for (int i = 0; i < 10; i++) begin
            btn_add = ~btn_add;
            cyc(2);
        end
        btn_add = 1'b0;
        cyc(20);
        chk("bounce_x", {ovf, x}, 9'h054);

        // Wrap / overflow
        press(1'b0, 8'h9C, 9'h0F0);
        press(1'b0, 8'h20, 9'h110);
        press(1'b0, 8'h01, 9'h111);
        drain("wrap");
        chk("wrap_x", {ovf, x}, 9'h111);

        // Reset while held in HOLD
        sw = 8'h33;
        exp_q.push_back(9'h144);
        btn_add = 1'b1;
        cyc(15);
        drain("hold_add");
        clr = 1'b1; btn_add = 1'b0;
        cyc(1);
        chk("reset_mid_hold", {upd, ovf, x}, 9'h000);
        clr = 1'b0;
        cyc(10);
        chk("after_reset_idle", {ovf, x}, 9'h000);

        // Borrow
        press(1'b0, 8'h05, 9'h005);
        press(1'b1, 8'h07, 9'h1FE);
        drain("borrow");
        chk("borrow_x", {ovf, x}, 9'h1FE);

        // Simultaneous presses: no operation
        sw = 8'h10;
        btn_add = 1'b1; btn_sub = 1'b1;
        cyc(30);
        btn_add = 1'b0; btn_sub = 1'b0;
        cyc(20);
        chk("simul_x", {ovf, x}, 9'h1FE);

        // Held add blocks a SUB press until all released
        sw = 8'h02;
        exp_q.push_back(9'h100);
        btn_add = 1'b1;
        cyc(15);
        btn_sub = 1'b1;
        cyc(15);
        btn_sub = 1'b0;
        cyc(15);
        btn_add = 1'b0;
        cyc(20);
        drain("held_add");
        chk("held_x", {ovf, x}, 9'h100);

        // Back in IDLE: a fresh SUB is accepted
        press(1'b1, 8'h01, 9'h1FF);
        drain("sub_after");
        chk("final_x", {ovf, x}, 9'h1FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
